// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage constants and types.
// Used by the fetch controller and its instruction buffer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] PC_INC     = 32'd4;
  localparam int          IBUF_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch bus: imem request/response, ID handshake, redirect.
// master = fetch controller, slave = its environment.
interface if_fetch_ctrl_if;

  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic [31:0] IDATA;
  logic        IREQ;
  logic [31:0] IADDR;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Instr_Valid;

  modport master (
    input  Stall, Redirect, Redirect_PC, IDATA,
    output IREQ, IADDR, Instr, Instr_PC, Instr_Valid
  );

  modport slave (
    output Stall, Redirect, Redirect_PC, IDATA,
    input  IREQ, IADDR, Instr, Instr_PC, Instr_Valid
  );

endinterface

// File: rtl/if_fetch_ctrl_ibuf.sv
// Two-entry instruction buffer holding {pc, instr}.
// Flush wins over enq; enq+deq together is a pass-through.
module fetch_ibuf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enq,
  input  logic       deq,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t mem [IBUF_DEPTH];
  logic   rd_ptr;
  logic   wr_ptr;

  assign head = mem[rd_ptr];

  // Pointer/count bookkeeping and storage writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, enq} - {1'b0, deq};
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: PC, credit-based imem
// requests, 1-cycle response bypass and redirect flush.
module if_fetch_ctrl
  import fetch_pkg::*;
(
  input logic           CLK,
  input logic           RSTN,
  if_fetch_ctrl_if.master bus
);

  logic [31:0] fetch_pc;
  logic [31:0] pending_pc;
  logic        pending;
  logic [31:0] tgt;
  logic [1:0]  count;
  entry_t      head;
  entry_t      din;
  logic        has_head;
  logic        bypass;
  logic        sel_head;
  logic        sel_byp;
  logic        valid;
  logic        deq;
  logic        enq;
  logic [2:0]  load;
  logic        issue;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  assign tgt      = {bus.Redirect_PC[31:2], 2'b00};
  assign has_head = count != 2'd0;
  assign bypass   = ~has_head & pending;
  assign sel_head = ~bus.Redirect & has_head;
  assign sel_byp  = ~bus.Redirect & bypass;
  assign valid    = sel_head | sel_byp;
  assign deq      = valid & ~bus.Stall;
  assign enq      = pending & ~bus.Redirect
                  & ~(bypass & deq);

  // Words held after this cycle; at most one more may be
  // requested while that stays within the buffer.
  assign load  = {1'b0, count} + {2'b00, pending}
               - {2'b00, deq};
  assign issue = bus.Redirect | (load <= 3'd1);

  assign bus.IREQ  = RSTN & issue;
  assign bus.IADDR = bus.Redirect ? tgt : fetch_pc;

  assign din.pc    = pending_pc;
  assign din.instr = bus.IDATA;

  fetch_ibuf u_ibuf (
    .clk   (CLK),
    .rst_n (RSTN),
    .enq   (enq),
    .deq   (deq & has_head),
    .flush (bus.Redirect),
    .din   (din),
    .head  (head),
    .count (count)
  );

  // Present buffer head first, else the arriving word.
  always_comb begin
    instr    = '0;
    instr_pc = '0;
    unique case (1'b1)
      sel_head: begin
        instr    = head.instr;
        instr_pc = head.pc;
      end
      sel_byp: begin
        instr    = bus.IDATA;
        instr_pc = pending_pc;
      end
      default: ;
    endcase
  end

  assign bus.Instr       = instr;
  assign bus.Instr_PC    = instr_pc;
  assign bus.Instr_Valid = valid;

  // Track the next fetch address and the in-flight request.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= RESET_PC;
    end else if (issue) begin
      pending    <= 1'b1;
      pending_pc <= bus.IADDR;
      fetch_pc   <= bus.IADDR + PC_INC;
    end else begin
      pending <= 1'b0;
    end
  end

endmodule
